// File: rtl/i2c_tgt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_tgt_pkg
//  Brief    : Shared types and widths for the I2C target register-file front end.
//  Revision : 1.0 - initial release
// ============================================================================
package i2c_tgt_pkg;

    localparam int I2C_BYTE_W = 8;
    localparam int ADDR_W     = 7;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ADDR  = 4'd1,
        ACK_A = 4'd2,
        PTR   = 4'd3,
        ACK_P = 4'd4,
        WDATA = 4'd5,
        ACK_W = 4'd6,
        RDATA = 4'd7,
        MACK  = 4'd8
    } tgt_state_e;

    function automatic logic [I2C_BYTE_W-1:0] ptr_next(input logic [I2C_BYTE_W-1:0] ptr);
        return ptr + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_line_filter
//  Brief    : 2-FF synchronizer, FILT_LEN-sample glitch filter and edge pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic arst_n,
    input  logic line_i,
    output logic line_o,
    output logic rise_o,
    output logic fall_o
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q,  filt_d;
    logic       prev_q,  prev_d;
    logic [3:0] cnt_q,   cnt_d;

    // The filtered value flips only after FILT_LEN consecutive differing samples.
    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = 4'd0;
        prev_d  = filt_q;
        if (sync2_q != filt_q) begin
            if (cnt_q == 4'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = filt_q;
    assign rise_o = filt_q & ~prev_q;
    assign fall_o = ~filt_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_target_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_target_regfile
//  Brief    : I2C target with address match, register pointer and register-file
//             strobes. I2C_TGT_AUTOINC_EN enables pointer auto-increment.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regfile
    import i2c_tgt_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DEV_ADDR = 7'h53,
    parameter int                FILT_LEN = 3
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic [I2C_BYTE_W-1:0] reg_addr,
    output logic [I2C_BYTE_W-1:0] reg_wdata,
    output logic                  reg_wr,
    output logic                  reg_rd,
    input  logic [I2C_BYTE_W-1:0] reg_rdata,
    output logic                  busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .arst_n (arst_n),
        .line_i (scl_i),
        .line_o (scl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .arst_n (arst_n),
        .line_i (sda_i),
        .line_o (sda),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    tgt_state_e            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [I2C_BYTE_W-1:0] shift_q, shift_d;
    logic [I2C_BYTE_W-1:0] reg_addr_q, reg_addr_d;
    logic [I2C_BYTE_W-1:0] reg_wdata_q, reg_wdata_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  reg_wr_q, reg_wr_d;
    logic                  reg_rd_q, reg_rd_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rw_q, rw_d;
    logic                  busy_q, busy_d;

    logic                  start_det;
    logic                  stop_det;
    logic                  byte_done;
    logic [I2C_BYTE_W-1:0] shift_in;

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
    assign shift_in  = {shift_q[I2C_BYTE_W-2:0], sda};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        sda_oe_d    = sda_oe_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        rd_pend_d   = reg_rd_q;
        rw_d        = rw_q;
        busy_d      = busy_q;

`ifdef I2C_TGT_AUTOINC_EN
        if (reg_wr_q) begin
            reg_addr_d = ptr_next(reg_addr_q);
        end
`endif

        if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = 4'd0;
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        if (shift_in[I2C_BYTE_W-1:1] == DEV_ADDR) begin
                            state_d  = ACK_A;
                            busy_d   = 1'b1;
                            rw_d     = shift_in[0];
                            reg_rd_d = shift_in[0];
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end

                // First fall pulls SDA for the ACK, second fall ends it.
                ACK_A: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (rw_q) begin
                            sda_oe_d  = ~shift_q[I2C_BYTE_W-1];
                            shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            bit_cnt_d = 4'd1;
                            state_d   = RDATA;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = PTR;
                        end
                    end
                end

                PTR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d  = 4'd0;
                        reg_addr_d = shift_in;
                        state_d    = ACK_P;
                    end
                end

                ACK_P, ACK_W: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = WDATA;
                        end
                    end
                end

                WDATA: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (byte_done) begin
                        bit_cnt_d   = 4'd0;
                        reg_wdata_d = shift_in;
                        reg_wr_d    = 1'b1;
                        state_d     = ACK_W;
                    end
                end

                RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = MACK;
                        end else begin
                            sda_oe_d  = ~shift_q[I2C_BYTE_W-1];
                            shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                // The pointer advances past every byte read, including the NACKed last one.
                MACK: begin
                    if (scl_rise) begin
`ifdef I2C_TGT_AUTOINC_EN
                        reg_addr_d = ptr_next(reg_addr_q);
`endif
                        bit_cnt_d = 4'd0;
                        if (!sda) begin
                            reg_rd_d = 1'b1;
                            state_d  = RDATA;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (rd_pend_q) begin
            shift_d = reg_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            sda_oe_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            sda_oe_q    <= sda_oe_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            rd_pend_q   <= rd_pend_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign reg_wr    = reg_wr_q;
    assign reg_rd    = reg_rd_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_target_regfile
//  Brief    : Directed bus-level bench for i2c_target_regfile.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_target_regfile;

    localparam int Q = 8;
`ifdef I2C_TGT_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       g_scl = 1'b0, g_sda = 1'b0;
    logic       sda_oe, reg_wr, reg_rd, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       sda_bus, scl_pin, sda_pin;
    logic [7:0] mem [256];

    assign sda_bus   = sda_m & ~sda_oe;
    assign scl_pin   = scl_m ^ g_scl;
    assign sda_pin   = sda_bus ^ g_sda;
    assign reg_rdata = mem[reg_addr];

    always #5 clk = ~clk;

    i2c_target_regfile #(.DEV_ADDR(7'h53), .FILT_LEN(3)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .scl_i     (scl_pin),
        .sda_i     (sda_pin),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         wr_cnt = 0, rd_cnt = 0, oe_cnt = 0, viol_cnt = 0;
    logic [7:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];

    // Strobe monitor: records writes and flags illegal strobe combinations.
    always @(negedge clk) begin
        if (reg_wr === 1'b1 && reg_rd === 1'b1) viol_cnt++;
        if ((reg_wr === 1'b1 || reg_rd === 1'b1) && (busy !== 1'b1 || arst_n !== 1'b1)) viol_cnt++;
        if (reg_wr === 1'b1) begin
            wr_addr_log[wr_cnt % 16] = reg_addr;
            wr_data_log[wr_cnt % 16] = reg_wdata;
            wr_cnt++;
        end
        if (reg_rd === 1'b1) rd_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(4 * Q);
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sda_m = b;
        if (glitch) begin
            tick(3); g_scl = 1'b1; tick(1); g_scl = 1'b0; tick(Q - 4);
        end else begin
            tick(Q);
        end
        scl_m = 1'b1;
        if (glitch) begin
            tick(4); g_sda = 1'b1; tick(1); g_sda = 1'b0; tick(2 * Q - 5);
        end else begin
            tick(2 * Q);
        end
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = (sda_bus === 1'b0);
        tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
            d[i] = sda_bus;
            tick(Q);
            scl_m = 1'b0; tick(Q);
        end
        send_bit(nack, 1'b0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd0, rd1;
        int         wr0, rd_base, oe_base;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h32] = 8'h5A;
        mem[8'h33] = 8'hC3;

        // Reset held for 4 clocks
        arst_n = 1'b0;
        tick(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_reg_addr", reg_addr, 8'h00);
        check("rst_reg_wdata", reg_wdata, 8'h00);
        check("rst_reg_wr", reg_wr, 0);
        check("rst_reg_rd", reg_rd, 0);
        arst_n = 1'b1;
        tick(8);

        // Single register write: 0x08 -> 0x2D
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA6, 1'b0, ack); check("t2_ack_addr", ack, 1);
        check("t2_busy_after_addr", busy, 1);
        write_byte(8'h2D, 1'b0, ack); check("t2_ack_ptr", ack, 1);
        write_byte(8'h08, 1'b0, ack); check("t2_ack_data", ack, 1);
        check("t2_busy_before_stop", busy, 1);
        i2c_stop();
        check("t2_busy_after_stop", busy, 0);
        check("t2_wr_count", wr_cnt - wr0, 1);
        check("t2_wr_addr", wr_addr_log[wr0 % 16], 8'h2D);
        check("t2_wr_data", wr_data_log[wr0 % 16], 8'h08);
        check("t2_ptr_after", reg_addr, AUTOINC ? 8'h2E : 8'h2D);

        // Pointer write, repeated START, two-byte read (ACK then NACK)
        wr0 = wr_cnt; rd_base = rd_cnt;
        i2c_start();
        write_byte(8'hA6, 1'b0, ack); check("t3_ack_addr_w", ack, 1);
        write_byte(8'h32, 1'b0, ack); check("t3_ack_ptr", ack, 1);
        i2c_start();
        write_byte(8'hA7, 1'b0, ack); check("t3_ack_addr_r", ack, 1);
        read_byte(1'b0, rd0);
        read_byte(1'b1, rd1);
        check("t3_busy_after_nack", busy, 0);
        i2c_stop();
        check("t3_rd_byte0", rd0, 8'h5A);
        check("t3_rd_byte1", rd1, AUTOINC ? 8'hC3 : 8'h5A);
        check("t3_ptr_end", reg_addr, AUTOINC ? 8'h34 : 8'h32);
        check("t3_rd_strobes", rd_cnt - rd_base, 2);
        check("t3_wr_strobes", wr_cnt - wr0, 0);

        // Address mismatch (0x1D): no ACK, no drive, no strobes
        wr0 = wr_cnt; rd_base = rd_cnt; oe_base = oe_cnt;
        i2c_start();
        write_byte(8'h3A, 1'b0, ack); check("t4_no_ack", ack, 0);
        check("t4_busy", busy, 0);
        write_byte(8'h55, 1'b0, ack); check("t4_no_ack_data", ack, 0);
        i2c_stop();
        check("t4_oe_cycles", oe_cnt - oe_base, 0);
        check("t4_strobes", (wr_cnt - wr0) + (rd_cnt - rd_base), 0);

        // Single-clock glitches on both lines during a write
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA6, 1'b1, ack); check("t5_ack_addr", ack, 1);
        write_byte(8'h40, 1'b1, ack); check("t5_ack_ptr", ack, 1);
        write_byte(8'h77, 1'b1, ack); check("t5_ack_data", ack, 1);
        check("t5_busy_held", busy, 1);
        i2c_stop();
        check("t5_wr_count", wr_cnt - wr0, 1);
        check("t5_wr_addr", wr_addr_log[wr0 % 16], 8'h40);
        check("t5_wr_data", wr_data_log[wr0 % 16], 8'h77);

        // STOP after 4 data bits: no write, back to idle
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA6, 1'b0, ack);
        write_byte(8'h20, 1'b0, ack);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        i2c_stop();
        check("t6_partial_no_wr", wr_cnt - wr0, 0);
        check("t6_partial_busy", busy, 0);
        check("t6_partial_ptr", reg_addr, 8'h20);

        // Two-byte burst write starting at 0x10
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA6, 1'b0, ack);
        write_byte(8'h10, 1'b0, ack);
        write_byte(8'h11, 1'b0, ack); check("t6_ack_b0", ack, 1);
        write_byte(8'h22, 1'b0, ack); check("t6_ack_b1", ack, 1);
        i2c_stop();
        check("t6_burst_count", wr_cnt - wr0, 2);
        check("t6_burst_addr0", wr_addr_log[wr0 % 16], 8'h10);
        check("t6_burst_addr1", wr_addr_log[(wr0 + 1) % 16], AUTOINC ? 8'h11 : 8'h10);
        check("t6_burst_data0", wr_data_log[wr0 % 16], 8'h11);
        check("t6_burst_data1", wr_data_log[(wr0 + 1) % 16], 8'h22);

        check("strobe_rules", viol_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
